// File: rtl/video_timing_rx.sv
// Video timing receiver: recovers pixel coordinates from incoming HS/VS/DE.
// Also measures line and frame geometry, and reports lock once the geometry is stable.
module video_timing_rx #(
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_de,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic [23:0] rgb_out,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic [11:0] h_total_meas,
  output logic [11:0] h_active_meas,
  output logic [11:0] v_total_meas,
  output logic [11:0] v_active_meas,
  output logic        locked
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK1   = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  lock_state_t state_reg, state_next;

  logic        s_hs_reg, s_vs_reg, s_de_reg;
  logic [23:0] s_rgb_reg;
  logic        p_hs_reg, p_vs_reg, p_de_reg;

  logic [11:0] h_cnt_reg, x_cnt_reg, de_run_reg, line_cnt_reg, de_line_reg;
  logic [11:0] x_cur, line_next, de_line_next, h_total_next, h_active_next;
  logic        hs_edge, vs_edge, de_fall;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [9:0] sat10(input logic [11:0] v);
    return (v > 12'd1023) ? 10'd1023 : v[9:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_hs_reg  <= 1'b0;
      s_vs_reg  <= 1'b0;
      s_de_reg  <= 1'b0;
      s_rgb_reg <= '0;
      p_hs_reg  <= 1'b0;
      p_vs_reg  <= 1'b0;
      p_de_reg  <= 1'b0;
    end else begin
      s_hs_reg  <= vga_hs;
      s_vs_reg  <= vga_vs;
      s_de_reg  <= vga_de;
      s_rgb_reg <= {vga_r, vga_g, vga_b};
      p_hs_reg  <= s_hs_reg;
      p_vs_reg  <= s_vs_reg;
      p_de_reg  <= s_de_reg;
    end
  end

  assign hs_edge = (s_hs_reg == HS_POL) && (p_hs_reg != HS_POL);
  assign vs_edge = (s_vs_reg == VS_POL) && (p_vs_reg != VS_POL);
  assign de_fall = p_de_reg && !s_de_reg;

  // The line increment is folded in before capture, so a VS edge that lands on an HS edge counts that line.
  always_comb begin
    x_cur         = hs_edge ? 12'd0 : x_cnt_reg;
    line_next     = hs_edge ? sat_inc(line_cnt_reg) : line_cnt_reg;
    de_line_next  = de_fall ? sat_inc(de_line_reg) : de_line_reg;
    h_total_next  = hs_edge ? sat_inc(h_cnt_reg) : h_total_meas;
    h_active_next = de_fall ? de_run_reg : h_active_meas;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_reg     <= '0;
      x_cnt_reg     <= '0;
      de_run_reg    <= '0;
      line_cnt_reg  <= '0;
      de_line_reg   <= '0;
      h_total_meas  <= '0;
      h_active_meas <= '0;
      v_total_meas  <= '0;
      v_active_meas <= '0;
    end else begin
      h_cnt_reg     <= hs_edge ? 12'd0 : sat_inc(h_cnt_reg);
      x_cnt_reg     <= s_de_reg ? sat_inc(x_cur) : x_cur;
      de_run_reg    <= s_de_reg ? sat_inc(de_run_reg) : 12'd0;
      h_total_meas  <= h_total_next;
      h_active_meas <= h_active_next;
      if (vs_edge) begin
        v_total_meas  <= line_next;
        v_active_meas <= de_line_next;
        line_cnt_reg  <= '0;
        de_line_reg   <= '0;
      end else begin
        line_cnt_reg  <= line_next;
        de_line_reg   <= de_line_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      rgb_out     <= '0;
    end else begin
      pix_valid   <= s_de_reg;
      pix_x       <= sat10(x_cur);
      pix_y       <= sat10(de_line_reg);
      frame_start <= s_de_reg && (x_cur == 12'd0) && (de_line_reg == 12'd0);
      if (s_de_reg) begin
        rgb_out <= s_rgb_reg;
      end
    end
  end

  // Per-field comparison of this frame's measurements against the previous frame's.
  logic [11:0] new_set [4];
  logic [3:0]  field_match, field_zero;
  logic        set_match;

  assign new_set[0] = h_total_next;
  assign new_set[1] = h_active_next;
  assign new_set[2] = line_next;
  assign new_set[3] = de_line_next;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_set
      logic [11:0] prev_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          prev_reg <= '0;
        end else if (vs_edge) begin
          prev_reg <= new_set[gi];
        end
      end
      assign field_match[gi] = (new_set[gi] == prev_reg);
      assign field_zero[gi]  = (new_set[gi] == 12'd0);
    end
  endgenerate

  assign set_match = (&field_match) && !(|field_zero);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= UNLOCKED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (vs_edge) begin
      if (!set_match) begin
        state_next = UNLOCKED;
      end else begin
        case (state_reg)
          UNLOCKED: state_next = CHECK1;
          CHECK1:   state_next = LOCKED;
          default:  state_next = LOCKED;
        endcase
      end
    end
  end

  assign locked = (state_reg == LOCKED);

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx: a stream generator with a per-cycle pixel scoreboard,
// plus measurement/lock checks at frame boundaries, on active-high and active-low HS instances.
module tb_video_timing_rx;

  localparam int H_TOT      = 800;
  localparam int H_ACT      = 640;
  localparam int HS_START   = 656;
  localparam int HS_LEN     = 96;
  localparam int V_TOT      = 5;
  localparam int V_ACT      = 3;
  localparam int LONG_FRAME = 4;

  typedef struct {
    logic        valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic hs_n;
  logic [7:0] r = '0, g = '0, b = '0;

  logic [23:0] rgb_out, rgb_out_n;
  logic        pix_valid, pix_valid_n, frame_start, frame_start_n, locked, locked_n;
  logic [9:0]  pix_x, pix_y, pix_x_n, pix_y_n;
  logic [11:0] h_total_meas, h_active_meas, v_total_meas, v_active_meas;
  logic [11:0] h_total_n, h_active_n, v_total_n, v_active_n;

  assign hs_n = ~hs;

  always #5 clk = ~clk;

  video_timing_rx dut (
    .clk(clk), .reset(reset),
    .vga_hs(hs), .vga_vs(vs), .vga_de(de),
    .vga_r(r), .vga_g(g), .vga_b(b),
    .rgb_out(rgb_out), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start),
    .h_total_meas(h_total_meas), .h_active_meas(h_active_meas),
    .v_total_meas(v_total_meas), .v_active_meas(v_active_meas),
    .locked(locked)
  );

  video_timing_rx #(.HS_POL(1'b0), .VS_POL(1'b1)) dut_n (
    .clk(clk), .reset(reset),
    .vga_hs(hs_n), .vga_vs(vs), .vga_de(de),
    .vga_r(r), .vga_g(g), .vga_b(b),
    .rgb_out(rgb_out_n), .pix_valid(pix_valid_n), .pix_x(pix_x_n), .pix_y(pix_y_n),
    .frame_start(frame_start_n),
    .h_total_meas(h_total_n), .h_active_meas(h_active_n),
    .v_total_meas(v_total_n), .v_active_meas(v_active_n),
    .locked(locked_n)
  );

  int tests_run = 0;
  int tests_failed = 0;

  exp_t sb_q[$];

  int g_frame = 0, g_line = 1, g_col = 100;
  int stall_left = 0;
  int rst_left = 3;

  int          m_x = 0, m_y = 0;
  logic [23:0] m_rgb = '0;
  logic        m_phs = 1'b0, m_pvs = 1'b0, m_pde = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic gen_drive();
    int hlen, hss;
    if (stall_left > 0) begin
      hs = 1'b0; vs = 1'b0; de = 1'b0;
      {r, g, b} = 24'($urandom);
      stall_left--;
    end else begin
      hlen = (g_frame == LONG_FRAME && g_line == V_TOT - 1) ? H_TOT + 1 : H_TOT;
      hss  = HS_START + (hlen - H_TOT);
      hs = (g_col >= hss) && (g_col < hss + HS_LEN);
      vs = (g_line == V_TOT - 1) && (g_col >= hss);
      de = (g_line < V_ACT) && (g_col < H_ACT);
      if (de) {r, g, b} = (g_col == H_ACT - 1) ? 24'hFFAABB : {g_col[7:0], 8'hAA, g_line[7:0]};
      else    {r, g, b} = 24'($urandom);
      g_col++;
      if (g_col == hlen) begin
        g_col = 0;
        g_line++;
        if (g_line == V_TOT) begin
          g_line = 0;
          g_frame++;
        end
      end
    end
  endtask

  task automatic model_clear();
    m_x = 0; m_y = 0; m_rgb = '0;
    m_phs = 1'b0; m_pvs = 1'b0; m_pde = 1'b0;
  endtask

  task automatic push_model();
    exp_t e;
    int   xc;
    logic he, ve, df;
    he = hs && !m_phs;
    ve = vs && !m_pvs;
    df = !de && m_pde;
    xc = he ? 0 : m_x;
    if (de) m_rgb = {r, g, b};
    e.valid = de;
    e.x     = (xc > 1023) ? 10'd1023 : 10'(xc);
    e.y     = (m_y > 1023) ? 10'd1023 : 10'(m_y);
    e.fs    = de && (xc == 0) && (m_y == 0);
    e.rgb   = m_rgb;
    sb_q.push_back(e);
    m_x = de ? xc + 1 : xc;
    if (ve) m_y = 0;
    else if (df) m_y++;
    m_phs = hs; m_pvs = vs; m_pde = de;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_left > 0) begin
      reset = 1'b1;
      rst_left--;
      #1;
      check("rst_rgb_out", 32'(rgb_out), 32'd0);
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      check("rst_pix_xy", {12'd0, pix_x, pix_y}, 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_meas_h", {8'd0, h_total_meas, h_active_meas}, 32'd0);
      check("rst_meas_v", {8'd0, v_total_meas, v_active_meas}, 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_locked_n", 32'(locked_n), 32'd0);
    end else begin
      if (reset) begin
        reset = 1'b0;
        sb_q.delete();
        model_clear();
      end
      if (sb_q.size() >= 2) begin
        e = sb_q.pop_front();
        check("pix_valid", 32'(pix_valid), 32'(e.valid));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("rgb_out", 32'(rgb_out), 32'(e.rgb));
        if (e.valid) begin
          check("pix_x", 32'(pix_x), 32'(e.x));
          check("pix_y", 32'(pix_y), 32'(e.y));
        end
      end
    end
    gen_drive();
    if (!reset) push_model();
  endtask

  task automatic run_to(input int f, input int l, input int c);
    int n;
    n = 0;
    while (!(g_frame == f && g_line == l && g_col == c)) begin
      step();
      n++;
      if (n > 12000) begin
        tests_run++;
        tests_failed++;
        $error("FAIL run_to_timeout observed=%0d steps expected=position %0d/%0d/%0d", n, f, l, c);
        return;
      end
    end
  endtask

  task automatic check_set(input string tag, input logic [11:0] ht, input logic [11:0] ha,
                           input logic [11:0] vt, input logic [11:0] va, input logic lk,
                           input int e_ht, input int e_ha, input int e_vt, input int e_va,
                           input int e_lk);
    check({tag, "_h_total"}, 32'(ht), e_ht);
    check({tag, "_h_active"}, 32'(ha), e_ha);
    check({tag, "_v_total"}, 32'(vt), e_vt);
    check({tag, "_v_active"}, 32'(va), e_va);
    check({tag, "_locked"}, 32'(lk), e_lk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stream resumes mid-frame after reset, so the first captured frame is partial.
    run_to(1, 0, 10);
    check_set("e1", h_total_meas, h_active_meas, v_total_meas, v_active_meas, locked,
              800, 640, 4, 2, 0);
    $display("[TB] VS1 h_total=%0d v_total=%0d locked=%0b", h_total_meas, v_total_meas, locked);
    run_to(2, 0, 10);
    check_set("e2", h_total_meas, h_active_meas, v_total_meas, v_active_meas, locked,
              800, 640, V_TOT, V_ACT, 0);
    check_set("e2n", h_total_n, h_active_n, v_total_n, v_active_n, locked_n,
              800, 640, V_TOT, V_ACT, 0);
    $display("[TB] VS2 h_total=%0d h_active=%0d locked=%0b", h_total_meas, h_active_meas, locked);
    run_to(3, 0, 10);
    check("e3_locked", 32'(locked), 32'd0);
    $display("[TB] VS3 locked=%0b", locked);
    run_to(4, 0, 10);
    check("e4_locked", 32'(locked), 32'd1);
    check("e4_locked_n", 32'(locked_n), 32'd1);
    $display("[TB] VS4 locked=%0b locked_n=%0b", locked, locked_n);

    run_to(5, 0, 10);
    check_set("e5", h_total_meas, h_active_meas, v_total_meas, v_active_meas, locked,
              801, 640, V_TOT, V_ACT, 0);
    check("e5_h_total_n", 32'(h_total_n), 32'd801);
    $display("[TB] VS5 long line h_total=%0d locked=%0b", h_total_meas, locked);
    run_to(6, 0, 10);
    check("e6_h_total", 32'(h_total_meas), 32'd800);
    check("e6_locked", 32'(locked), 32'd0);
    $display("[TB] VS6 locked=%0b", locked);
    run_to(7, 0, 10);
    check("e7_locked", 32'(locked), 32'd0);
    $display("[TB] VS7 locked=%0b", locked);
    run_to(8, 0, 10);
    check("e8_locked", 32'(locked), 32'd1);
    $display("[TB] VS8 relock locked=%0b", locked);

    run_to(8, 1, 100);
    rst_left = 3;
    run_to(9, 0, 10);
    check_set("e9", h_total_meas, h_active_meas, v_total_meas, v_active_meas, locked,
              800, 640, 4, 2, 0);
    $display("[TB] VS9 after reset v_total=%0d locked=%0b", v_total_meas, locked);
    run_to(10, 0, 10);
    check("e10_locked", 32'(locked), 32'd0);
    run_to(11, 0, 10);
    check("e11_locked", 32'(locked), 32'd0);
    run_to(12, 0, 10);
    check("e12_locked", 32'(locked), 32'd1);
    check("e12_locked_n", 32'(locked_n), 32'd1);
    $display("[TB] VS12 locked=%0b locked_n=%0b", locked, locked_n);

    stall_left = 4200;
    run_to(12, 0, 700);
    check("sat_h_total", 32'(h_total_meas), 32'd4095);
    check("sat_h_total_n", 32'(h_total_n), 32'd4095);
    $display("[TB] stalled HS h_total=%0d h_total_n=%0d", h_total_meas, h_total_n);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/video_timing_rx.md
VIDEO_TIMING_RX -- requirements
Module: video_timing_rx

Interface
REQ-001 The module SHALL have parameter HS_POL, default 1, meaning the asserted level of vga_hs (1 = active-high).
REQ-002 The module SHALL have parameter VS_POL, default 1, meaning the asserted level of vga_vs.
REQ-003 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-004 The module SHALL have port clk, input, 1 bit, meaning pixel clock; all logic rises on it.
REQ-005 The module SHALL have port reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-006 The module SHALL have ports vga_hs, vga_vs and vga_de, each input, 1 bit, meaning incoming sync and data-enable.
REQ-007 The module SHALL have ports vga_r, vga_g and vga_b, each input, 8 bits, meaning incoming pixel colour.
REQ-008 The module SHALL have port rgb_out, output, 24 bits, meaning {r,g,b} of the recovered pixel.
REQ-009 The module SHALL have port pix_valid, output, 1 bit, meaning rgb_out/pix_x/pix_y are an active pixel.
REQ-010 The module SHALL have ports pix_x and pix_y, each output, 10 bits, meaning recovered pixel column/row.
REQ-011 The module SHALL have port frame_start, output, 1 bit, meaning one-cycle pulse with pixel (0,0).
REQ-012 The module SHALL have ports h_total_meas, h_active_meas, v_total_meas and v_active_meas, each output, 12 bits, meaning measured timing.
REQ-013 The module SHALL have port locked, output, 1 bit, meaning timing stable over consecutive frames.

Function
REQ-014 The module SHALL register all inputs once (stage S); edge detection SHALL compare S against its own previous value (stage P).
REQ-015 The module SHALL present rgb_out, pix_valid, pix_x, pix_y and frame_start exactly 2 clk cycles after the corresponding input sample.
REQ-016 The module SHALL define an HS edge as S_hs==HS_POL with P_hs!=HS_POL; VS edge analogously with VS_POL.
REQ-017 The module SHALL reset a free-running 12-bit h counter to 0 on an HS edge; otherwise it increments, saturating at 4095.
REQ-018 On an HS edge, the module SHALL load h_total_meas with h counter+1, saturated at 4095.
REQ-019 The module SHALL hold an x counter that increments on each S_de=1 cycle and clears on an HS edge; pix_x SHALL equal its value before increment, saturating at 1023.
REQ-020 On the S_de 1->0 transition, the module SHALL load h_active_meas with the DE run length of that line (12 bits, saturating).
REQ-021 The module SHALL hold a line counter that increments on each HS edge, and a DE-line counter that increments on each S_de 1->0 transition; both SHALL clear on a VS edge.
REQ-022 pix_y SHALL equal the DE-line counter, saturating at 1023.
REQ-023 On a VS edge, the module SHALL load v_total_meas with the line count and v_active_meas with the DE-line count, before clearing both counters.
REQ-024 When a VS edge and an HS edge coincide, the HS line increment SHALL be applied before capture.
REQ-025 frame_start SHALL be 1 only when pix_valid=1, pix_x=0 and pix_y=0.
REQ-026 Lock FSM states SHALL be UNLOCKED, CHECK1 and LOCKED, evaluated on every VS edge by comparing the four new measurements with the previous frame's set.
REQ-027 In UNLOCKED, a match SHALL go to CHECK1.
REQ-028 In CHECK1, a match SHALL go to LOCKED.
REQ-029 In any state, a mismatch SHALL go to UNLOCKED.
REQ-030 A set containing a zero SHALL count as a mismatch.
REQ-031 locked SHALL be 1 only in LOCKED.
REQ-032 The module SHALL store the previous set on every VS edge regardless of match.

Reset
REQ-033 Reset SHALL asynchronously clear all outputs, counters, stored measurements and S/P stages to 0, with the FSM in UNLOCKED.
REQ-034 Reset asserted mid-line or mid-frame SHALL discard partial counts, and the first VS edge after release SHALL be treated as a mismatch.
REQ-035 rgb_out SHALL hold its last value when pix_valid=0.

Verification
REQ-036 Reset held 3 cycles mid-stream -> all outputs 0 and locked=0 during reset and until re-lock.
REQ-037 Continuous 800x525 stream, DE 640x480, rgb 24'hFFAABB, active-high syncs -> h_total_meas=800, h_active_meas=640, v_total_meas=525, v_active_meas=480, locked=1 after 4th VS edge.
REQ-038 Same stream -> first DE cycle of a frame gives pix_x=0, pix_y=0, frame_start=1 two cycles later; last pixel of the frame gives pix_x=639, pix_y=479, rgb_out=24'hFFAABB.
REQ-039 After lock, one line lengthened to 801 cycles -> that line's h_total_meas=801, mismatch at next VS edge, locked drops, and re-locks after two further clean frames.
REQ-040 HS_POL=0 with inverted hs -> measurements identical to the REQ-037 scenario.
REQ-041 vga_hs held static for >4096 cycles -> h counter saturates at 4095 with no wrap, and next HS edge gives h_total_meas=4095.
